// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Op codes are also consumed by the control/decode path.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Shift-add multiply and restoring divide share one 2*WIDTH work register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_in;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q, sign_r, dz_q;

  logic               in_signed, in_div, accept, mt_ok;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_mag     = (in_signed & opa[WIDTH-1]) ? -opa : opa;
  assign b_mag     = (in_signed & opb[WIDTH-1]) ? -opb : opb;
  assign accept    = start & (state_q == IDLE);
  assign mt_ok     = ~start & (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
             + (work_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    rem_sh   = work_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, b_q};
    // No borrow means the shifted remainder covers the divisor.
    if (!rem_diff[WIDTH])
      div_next = {rem_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    else
      div_next = {work_q[2*WIDTH-2:0], 1'b0};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = sign_q ? -work_q : work_q;
    quo_fix  = sign_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = sign_r ? -work_q[2*WIDTH-1:WIDTH]
                      : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_MULT;
      work_q      <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        op_q   <= op_in;
        work_q <= {{WIDTH{1'b0}}, in_div ? a_mag : b_mag};
        b_q    <= in_div ? b_mag : a_mag;
        cnt_q  <= '0;
        sign_q <= in_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        sign_r <= in_signed & opa[WIDTH-1];
        dz_q   <= in_div & (opb == '0);
      end else if (state_q == CALC) begin
        work_q <= op_is_div(op_q) ? div_next : mul_next;
        cnt_q  <= cnt_q + 1'b1;
      end else if (state_q == FIX) begin
        done        <= 1'b1;
        div_by_zero <= dz_q;
        if (op_is_div(op_q)) begin
          hi <= rem_fix;
          lo <= dz_q ? WIDTH'(DIV0_LO) : quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end else if (mt_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic HI/LO model.
// Also covers MTHI/MTLO, ignored restarts and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [31:0] a, b,
                                output logic [31:0] h, l,
                                output logic z);
    longint sa, sb, sp;
    logic [63:0] up;
    int si, sj;
    z = 1'b0;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        h = sp[63:32]; l = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32]; l = up[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 0; l = 32'h8000_0000;
        end else begin
          si = $signed(a); sj = $signed(b);
          l = si / sj; h = si % sj;
        end
      end
      default: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  task automatic run(input logic [1:0] o, input logic [31:0] a, b,
                     input bit disturb);
    logic [31:0] eh, el, h0, l0;
    logic ez;
    int n;
    bit stable;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom;
    h0 = hi; l0 = lo;
    chk("busy_e0", 64'(busy), 64'd1);
    n = 0; stable = 1'b1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; op = OP_DIVU; opa = $urandom; opb = $urandom;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
      end
      if (disturb && n == 6) begin
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
      end
      if (!done && (hi !== h0 || lo !== l0 || busy !== 1'b1))
        stable = 1'b0;
    end
    chk("latency", 64'(n), 64'd33);
    chk("stable", 64'(stable), 64'd1);
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("dz", 64'(div_by_zero), 64'(ez));
    chk("busy_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("pulse_clr", 64'({done, div_by_zero}), 64'd0);
  endtask

  task automatic mt(input logic hw, lw, input logic [31:0] d,
                    input logic [31:0] eh, el);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_hi", 64'(hi), 64'(eh));
    chk("mt_lo", 64'(lo), 64'(el));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] h_keep;
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = 0; opb = 0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'({done, div_by_zero}), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(OP_MULT,  32'd7, 32'hFFFF_FFFD, 1'b0);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run(OP_DIVU,  32'd100, 32'd7, 1'b0);
    run(OP_DIVU,  32'd100, 32'd0, 1'b0);
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(OP_DIV,   32'hFFFF_FFF0, 32'd0, 1'b0);
    run(OP_MULT,  32'h0001_0003, 32'h0002_0005, 1'b1);

    h_keep = hi;
    mt(1'b0, 1'b1, 32'h1234, h_keep, 32'h1234);
    mt(1'b1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D);
    mt(1'b1, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA, 32'hCAFE_F00D);

    @(negedge clk);
    op = OP_DIV; opa = 32'd1000; opb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(OP_DIVU, 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++)
      run(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
